psum_adder: RTL and testbench

//  Accumulation stage enabled by the layer control FSM through adder_en. Sums a stream
//  of multi-lane partial sums from the PE array over num_terms beats. Hands the
//  per-lane totals downstream to the output writer, then pulses adder_done back to
//  the FSM. Sits between the PE array (upstream) and the output write stage (downstream).

---
 rtl/psum_adder.sv | 113 +++++++++++
 tb/tb_psum_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_adder.sv
// psum_adder: sums num_terms beats of signed multi-lane partial sums and hands the per-lane totals downstream.
// Define PSUM_ADDER_SAT_EN for saturating lane adds; the default build wraps modulo 2^ACC_W.
module psum_adder #(
    parameter  int DATA_W    = 16,
    parameter  int ACC_W     = 32,
    parameter  int LANES     = 4,
    parameter  int MAX_TERMS = 16,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adder_en,
    input  logic [CNT_W-1:0]        num_terms,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [LANES*DATA_W-1:0] psum_data,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [LANES*ACC_W-1:0]  sum_data,
    output logic                    adder_done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q [LANES];
    logic [ACC_W-1:0] acc_d [LANES];

    // One lane step: add the sign-extended partial sum to the running total.
    function automatic logic [ACC_W-1:0] lane_add(input logic [ACC_W-1:0]  acc,
                                                  input logic [DATA_W-1:0] d);
`ifdef PSUM_ADDER_SAT_EN
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){d[DATA_W-1]}}, d};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return sum[ACC_W-1:0];
`else
        return acc + ACC_W'($signed(d));
`endif
    endfunction

    // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        terms_d = terms_q;
        count_d = count_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (adder_en) begin
                    terms_d = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;
                    count_d = '0;
                    for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                    state_d = (num_terms == '0) ? OUT : ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = lane_add(acc_q[i], psum_data[i*DATA_W +: DATA_W]);
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == terms_q - CNT_W'(1)) state_d = OUT;
                end
            end
            OUT: begin
                if (sum_ready) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: accumulators are reset as well, because sum_data exposes them directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            terms_q <= '0;
            count_q <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            terms_q <= terms_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    assign psum_ready = (state_q == ACCUM);
    assign sum_valid  = (state_q == OUT);
    assign adder_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);

    always_comb begin
        sum_data = '0;
        for (int i = 0; i < LANES; i++) sum_data[i*ACC_W +: ACC_W] = acc_q[i];
    end

endmodule

// File: tb/tb_psum_adder.sv
// tb_psum_adder: scoreboard bench for psum_adder; a wide (ACC_W=32) and a narrow (ACC_W=16) instance share stimulus.
// Expected totals follow PSUM_ADDER_SAT_EN the same way the design does.
module tb_psum_adder;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 32;
    localparam int NARROW_W  = 16;
    localparam int LANES     = 4;
    localparam int MAX_TERMS = 16;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    typedef logic [LANES*DATA_W-1:0] beat_t;
    typedef struct {
        logic [LANES*ACC_W-1:0]    wide;
        logic [LANES*NARROW_W-1:0] narrow;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      adder_en;
    logic [CNT_W-1:0]          num_terms;
    logic                      psum_valid;
    beat_t                     psum_data;
    logic                      sum_ready;
    logic                      psum_ready, sum_valid, adder_done, busy;
    logic [LANES*ACC_W-1:0]    sum_data;
    logic                      psum_ready_n, sum_valid_n, adder_done_n, busy_n;
    logic [LANES*NARROW_W-1:0] sum_data_n;

    exp_t  sb_q[$];
    beat_t beats[$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;

    psum_adder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES), .MAX_TERMS(MAX_TERMS)) u_dut (
        .clk(clk), .rst(rst), .adder_en(adder_en), .num_terms(num_terms),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
        .adder_done(adder_done), .busy(busy)
    );

    psum_adder #(.DATA_W(DATA_W), .ACC_W(NARROW_W), .LANES(LANES), .MAX_TERMS(MAX_TERMS)) u_dut_n (
        .clk(clk), .rst(rst), .adder_en(adder_en), .num_terms(num_terms),
        .psum_valid(psum_valid), .psum_ready(psum_ready_n), .psum_data(psum_data),
        .sum_valid(sum_valid_n), .sum_ready(sum_ready), .sum_data(sum_data_n),
        .adder_done(adder_done_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference lane step on plain integers: wrap to w bits, or clamp when saturating.
    function automatic longint fold(input longint acc, input longint d, input int w);
        longint s;
        longint lim;
        s   = acc + d;
        lim = longint'(1) <<< (w - 1);
`ifdef PSUM_ADDER_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
`else
        s = s & ((lim <<< 1) - 1);
        if (s >= lim) s = s - (lim <<< 1);
`endif
        return s;
    endfunction

    function automatic beat_t mk_beat(input int v0, input int v1, input int v2, input int v3);
        beat_t b;
        b[0*DATA_W +: DATA_W] = v0[DATA_W-1:0];
        b[1*DATA_W +: DATA_W] = v1[DATA_W-1:0];
        b[2*DATA_W +: DATA_W] = v2[DATA_W-1:0];
        b[3*DATA_W +: DATA_W] = v3[DATA_W-1:0];
        return b;
    endfunction

    // Monitor: count done pulses, and pop/compare the scoreboard on every sum handshake.
    always @(negedge clk) begin
        if (adder_done) done_cnt++;
        if (sum_valid && sum_ready) begin
            check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) begin
                check("sum_wide", sum_data, sb_q[0].wide);
                check("sum_narrow", 128'(sum_data_n), 128'(sb_q[0].narrow));
                void'(sb_q.pop_front());
            end
        end
    end

    // One full job: start, offer the beats queue, optionally stall the result, then finish.
    task automatic run_job(input int n, input bit gappy, input int hold, input bit en_in_out);
        longint acc_w [LANES];
        longint acc_n [LANES];
        longint d;
        exp_t   e;
        beat_t  b;
        int     n_eff, accepted, done0, g;
        bit     at_neg;
        n_eff = (n > MAX_TERMS) ? MAX_TERMS : n;
        for (int l = 0; l < LANES; l++) begin
            acc_w[l] = 0;
            acc_n[l] = 0;
        end
        for (int k = 0; k < n_eff; k++) begin
            b = beats[k];
            for (int l = 0; l < LANES; l++) begin
                d = longint'($signed(b[l*DATA_W +: DATA_W]));
                acc_w[l] = fold(acc_w[l], d, ACC_W);
                acc_n[l] = fold(acc_n[l], d, NARROW_W);
            end
        end
        e.wide   = '0;
        e.narrow = '0;
        for (int l = 0; l < LANES; l++) begin
            e.wide[l*ACC_W +: ACC_W]          = acc_w[l][ACC_W-1:0];
            e.narrow[l*NARROW_W +: NARROW_W]  = acc_n[l][NARROW_W-1:0];
        end
        sb_q.push_back(e);
        done0 = done_cnt;

        adder_en  = 1'b1;
        num_terms = CNT_W'(n);
        tick();
        adder_en  = 1'b0;

        accepted = 0;
        at_neg   = 1'b0;
        for (int k = 0; k < beats.size(); k++) begin
            @(negedge clk);
            if (k == 0) check("busy_after_start", 128'(busy), 128'(1));
            if (!psum_ready) begin
                at_neg = 1'b1;
                break;
            end
            g = gappy ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                psum_valid = 1'b0;
                repeat (g) tick();
            end
            psum_valid = 1'b1;
            psum_data  = beats[k];
            tick();
            accepted++;
        end
        psum_valid = 1'b0;
        if (!at_neg) @(negedge clk);
        check("beats_taken", 128'(accepted), 128'(n_eff));
        check("sum_valid_latency", 128'(sum_valid), 128'(1));

        for (int h = 0; h < hold; h++) begin
            if (en_in_out && h == 0) adder_en = 1'b1;
            tick();
            adder_en = 1'b0;
            @(negedge clk);
            check("hold_valid", 128'(sum_valid), 128'(1));
            if (sb_q.size() != 0) check("hold_stable", sum_data, sb_q[0].wide);
        end

        tick();
        sum_ready = 1'b1;
        @(negedge clk);
        tick();
        sum_ready = 1'b0;
        @(negedge clk);
        check("done_latency", 128'(adder_done), 128'(1));
        check("valid_dropped", 128'(sum_valid), 128'(0));
        tick();
        check("one_done", 128'(done_cnt - done0), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst        = 1'b1;
        adder_en   = 1'b1;
        num_terms  = CNT_W'(3);
        psum_valid = 1'b0;
        psum_data  = '0;
        sum_ready  = 1'b0;

        // Reset held 4 cycles with adder_en asserted throughout.
        repeat (4) @(negedge clk);
        check("rst_psum_ready", 128'(psum_ready), 128'(0));
        check("rst_sum_valid", 128'(sum_valid), 128'(0));
        check("rst_adder_done", 128'(adder_done), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_sum_data", sum_data, 128'(0));
        tick();
        rst      = 1'b0;
        adder_en = 1'b0;
        @(negedge clk);
        check("rst_en_ignored", 128'(busy), 128'(0));

        // Basic: lane0 = 5, -2, 7; other lanes 1 each.
        beats = {mk_beat(5, 1, 1, 1), mk_beat(-2, 1, 1, 1), mk_beat(7, 1, 1, 1)};
        run_job(3, 1'b0, 0, 1'b0);

        // Stalls: gapped beats, result held off for 5 cycles.
        beats.delete();
        for (int k = 0; k < 6; k++) beats.push_back(beat_t'({$urandom, $urandom}));
        run_job(6, 1'b1, 5, 1'b0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        check("stall_single_done", 128'(done_cnt), 128'(d0));

        // Zero terms (the offered beat must be ignored), then clamp 20 -> 16.
        beats = {mk_beat(9, 9, 9, 9)};
        run_job(0, 1'b0, 0, 1'b0);
        beats.delete();
        for (int k = 0; k < 20; k++) beats.push_back(mk_beat(k + 1, -(k + 1), 100 * k, 1));
        run_job(20, 1'b0, 0, 1'b0);

        // Overflow: positive and negative extremes twice.
        beats = {mk_beat(32'h7FFF, -32768, 32'h7FFF, -1), mk_beat(32'h7FFF, -32768, 32'h7FFF, -1)};
        run_job(2, 1'b0, 0, 1'b0);

        // Abort: reset in ACCUM after 2 of 5 beats.
        d0        = done_cnt;
        adder_en  = 1'b1;
        num_terms = CNT_W'(5);
        tick();
        adder_en   = 1'b0;
        psum_valid = 1'b1;
        psum_data  = mk_beat(100, 200, 300, 400);
        tick();
        psum_data  = mk_beat(1, 2, 3, 4);
        tick();
        psum_valid = 1'b0;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_psum_ready", 128'(psum_ready), 128'(0));
        check("abort_sum_valid", 128'(sum_valid), 128'(0));
        check("abort_sum_data", sum_data, 128'(0));
        check("abort_sum_data_n", 128'(sum_data_n), 128'(0));
        repeat (4) @(negedge clk);
        check("abort_no_done", 128'(done_cnt), 128'(d0));

        // adder_en pulsed while in OUT must not start another job.
        beats = {mk_beat(10, 20, 30, 40), mk_beat(-1, -2, -3, -4)};
        run_job(2, 1'b0, 3, 1'b1);
        @(negedge clk);
        check("en_in_out_ignored", 128'(busy), 128'(0));
        @(negedge clk);
        check("en_in_out_idle", 128'(busy), 128'(0));

        // Back-to-back: second start lands at the earliest accepted cycle.
        beats = {mk_beat(1000, -1000, 3, 4), mk_beat(2000, -2000, 5, 6),
                 mk_beat(-500, 500, 7, 8), mk_beat(1, 1, 1, 1)};
        run_job(4, 1'b0, 0, 1'b0);
        beats = {mk_beat(11, 22, 33, 44), mk_beat(-11, -22, -33, -44), mk_beat(5, 6, 7, 8)};
        run_job(3, 1'b1, 2, 1'b0);

        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
